// File: rtl/id_queue_multi.sv
// Multi-lane in-order ID queue: all-or-nothing group writes and clipped multi-entry pops.
// Lane 0 is always the oldest entry on both the write and read sides.
module id_queue_multi #(
    parameter int ENTRY_W   = 96,
    parameter int PTR_W     = 3,
    parameter int LANES     = 2,
    parameter int AFULL_LVL = (1 << PTR_W) - LANES,
    localparam int NUM_W    = $clog2(LANES + 1)
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       FREEZE,
    input  logic                       mispredict,
    input  logic                       flush_fCOM,
    input  logic [NUM_W-1:0]           wr_num,
    input  logic [LANES*ENTRY_W-1:0]   data_in,
    input  logic [NUM_W-1:0]           rd_num,
    output logic                       wr_accept,
    output logic [LANES*ENTRY_W-1:0]   data_out,
    output logic [LANES-1:0]           out_valid,
    output logic [PTR_W:0]             count,
    output logic                       empty_FIFO,
    output logic                       full_FIFO,
    output logic                       almost_full
);
    localparam int DEPTH = 1 << PTR_W;
    localparam int CW    = PTR_W + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] LANES_C = CW'(LANES);
    localparam logic [CW-1:0] AFULL_C = CW'(AFULL_LVL);

    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [CW-1:0]      r_count;

    logic               w_flush;
    logic               w_accept;
    logic [CW-1:0]      w_wr_n;
    logic [CW-1:0]      w_rd_n;
    logic [CW-1:0]      w_rd_eff;
    logic [CW-1:0]      w_space;

    // Requests above LANES saturate; pops are clipped to what is present.
    always_comb begin
        w_flush  = mispredict || flush_fCOM;
        w_wr_n   = (CW'(wr_num) > LANES_C) ? LANES_C : CW'(wr_num);
        w_rd_n   = (CW'(rd_num) > LANES_C) ? LANES_C : CW'(rd_num);
        w_rd_eff = (w_rd_n < r_count) ? w_rd_n : r_count;
        w_space  = DEPTH_C - r_count;
        w_accept = RESET && !FREEZE && !w_flush && (w_wr_n != '0) && (w_space >= w_wr_n);
    end

    always_ff @(posedge CLK) begin
        if (!RESET || w_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (!FREEZE) begin
            if (w_accept) begin
                r_tail <= r_tail + w_wr_n[PTR_W-1:0];
            end
            r_head  <= r_head + w_rd_eff[PTR_W-1:0];
            r_count <= r_count + (w_accept ? w_wr_n : '0) - w_rd_eff;
        end
    end

    // Storage is never cleared; stale entries are hidden by out_valid masking.
    always_ff @(posedge CLK) begin
        for (int k = 0; k < LANES; k++) begin
            if (w_accept && (CW'(k) < w_wr_n)) begin
                r_mem[r_tail + PTR_W'(k)] <= data_in[k*ENTRY_W +: ENTRY_W];
            end
        end
    end

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [PTR_W-1:0] w_idx;
        assign w_idx                           = r_head + PTR_W'(gi);
        assign out_valid[gi]                   = (r_count > CW'(gi));
        assign data_out[gi*ENTRY_W +: ENTRY_W] = out_valid[gi] ? r_mem[w_idx] : '0;
    end

    assign wr_accept   = w_accept;
    assign count       = r_count;
    assign empty_FIFO  = (r_count == '0);
    assign full_FIFO   = (r_count == DEPTH_C);
    assign almost_full = (r_count >= AFULL_C);

endmodule

// File: tb/tb_id_queue_multi.sv
// Bench for id_queue_multi: directed scenarios then random traffic against a queue-based model.
module tb_id_queue_multi;
    localparam int ENTRY_W = 96;
    localparam int LANES   = 2;
    localparam int DEPTH   = 8;
    localparam int AFULL   = DEPTH - LANES;

    logic                     CLK = 1'b0;
    logic                     RESET;
    logic                     FREEZE;
    logic                     mispredict;
    logic                     flush_fCOM;
    logic [1:0]               wr_num;
    logic [LANES*ENTRY_W-1:0] data_in;
    logic [1:0]               rd_num;
    logic                     wr_accept;
    logic [LANES*ENTRY_W-1:0] data_out;
    logic [LANES-1:0]         out_valid;
    logic [3:0]               count;
    logic                     empty_FIFO;
    logic                     full_FIFO;
    logic                     almost_full;

    int tests = 0;
    int fails = 0;
    logic [ENTRY_W-1:0] mq [$];

    id_queue_multi dut (
        .CLK(CLK), .RESET(RESET), .FREEZE(FREEZE), .mispredict(mispredict),
        .flush_fCOM(flush_fCOM), .wr_num(wr_num), .data_in(data_in), .rd_num(rd_num),
        .wr_accept(wr_accept), .data_out(data_out), .out_valid(out_valid), .count(count),
        .empty_FIFO(empty_FIFO), .full_FIFO(full_FIFO), .almost_full(almost_full)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [LANES*ENTRY_W-1:0] obs,
                       input logic [LANES*ENTRY_W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_state();
        logic [LANES*ENTRY_W-1:0] exp_d;
        logic [LANES-1:0]         exp_v;
        int n;
        n     = mq.size();
        exp_d = '0;
        exp_v = '0;
        for (int k = 0; k < LANES; k++) begin
            if (k < n) begin
                exp_v[k] = 1'b1;
                exp_d[k*ENTRY_W +: ENTRY_W] = mq[k];
            end
        end
        chk("count", count, n);
        chk("empty_FIFO", empty_FIFO, n == 0);
        chk("full_FIFO", full_FIFO, n == DEPTH);
        chk("almost_full", almost_full, n >= AFULL);
        chk("out_valid", out_valid, exp_v);
        chk("data_out", data_out, exp_d);
    endtask

    // One clock of stimulus; rstn=0 drives RESET low.
    task automatic step(input int wr, input int rd, input bit frz, input bit mp,
                        input bit fc, input bit rstn);
        logic [LANES*ENTRY_W-1:0] din;
        int wn, rn, n, pops;
        bit exp_acc;
        @(negedge CLK);
        for (int w = 0; w < LANES*ENTRY_W/32; w++) din[w*32 +: 32] = $urandom;
        data_in    = din;
        wr_num     = 2'(wr);
        rd_num     = 2'(rd);
        FREEZE     = frz;
        mispredict = mp;
        flush_fCOM = fc;
        RESET      = rstn;
        wn = (wr > LANES) ? LANES : wr;
        rn = (rd > LANES) ? LANES : rd;
        n  = mq.size();
        exp_acc = rstn && !(mp || fc) && !frz && (wn != 0) && ((DEPTH - n) >= wn);
        #1 chk("wr_accept", wr_accept, exp_acc);
        @(posedge CLK);
        if (!rstn || mp || fc) begin
            mq.delete();
        end else if (!frz) begin
            pops = (rn < n) ? rn : n;
            repeat (pops) void'(mq.pop_front());
            if (exp_acc) for (int k = 0; k < wn; k++) mq.push_back(din[k*ENTRY_W +: ENTRY_W]);
        end
        #1 check_state();
    endtask

    initial begin
        RESET = 1'b0; FREEZE = 1'b0; mispredict = 1'b0; flush_fCOM = 1'b0;
        wr_num = '0; rd_num = '0; data_in = '0;

        // Reset held low while offering writes
        step(2, 0, 0, 0, 0, 0);
        step(2, 0, 0, 0, 0, 0);

        // Fill to full with pairs, then a rejected fifth pair
        repeat (4) step(2, 0, 0, 0, 0, 1);
        step(2, 0, 0, 0, 0, 1);

        // Full: simultaneous pop 2 / write 2 -> write rejected, count 6
        step(2, 2, 0, 0, 0, 1);

        // count 6 -> 7 with one, then two rejected, then one accepted to full
        step(1, 0, 0, 0, 0, 1);
        step(2, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 1);

        // Flush, then position a group write across the wrap point
        step(0, 0, 0, 1, 0, 1);
        repeat (3) step(2, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 1);
        repeat (3) step(0, 2, 0, 0, 0, 1);
        step(2, 0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 1);

        // Over-request pop clipped to count
        step(0, 1, 0, 0, 0, 1);
        step(0, 2, 0, 0, 0, 1);
        step(0, 3, 0, 0, 0, 1);

        // Flush beats FREEZE; FREEZE holds; reset beats a write
        step(2, 0, 0, 0, 0, 1);
        step(2, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 1);
        step(2, 1, 1, 1, 0, 1);
        step(3, 0, 0, 0, 0, 1);
        step(2, 1, 1, 0, 0, 1);
        step(2, 2, 0, 0, 1, 1);
        step(2, 0, 0, 0, 0, 1);
        step(2, 1, 1, 0, 1, 0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            int r;
            r = $urandom_range(0, 99);
            step($urandom_range(0, 3), $urandom_range(0, 3),
                 r < 10, (r >= 10) && (r < 13), (r >= 13) && (r < 16), r < 97);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
